// File: rtl/scoreboard_register_file.sv
// ---------------------------------------------------------------------------------------------
// scoreboard_register_file
//
// Purpose:
//   WIDTH x DEPTH integer register file with NUM_READ combinational read ports, one synchronous
//   write-back port and a per-register busy scoreboard. Decode/issue marks a destination busy
//   through the issue handshake; write-back clears it. The top register (stack pointer) resets
//   to SP_INIT, all others to zero. A registered population count of busy bits is kept.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN - when defined, a read port whose address matches an active write-back
//                       returns write_data and reports not-busy in the same cycle. When
//                       undefined, reads always return stored state.
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_reset         synchronous active-high reset
//   i_read_addr     packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   o_read_data     packed read data, port i at [i*WIDTH +: WIDTH]
//   o_read_busy     per-port busy flag of the addressed register
//   i_issue_valid   request to mark i_issue_addr busy
//   i_issue_addr    destination register being issued
//   o_issue_ready   issue is accepted this cycle (combinational)
//   i_write_enable  write-back strobe
//   i_write_addr    write-back destination
//   i_write_data    write-back value
//   o_busy_count    number of busy registers (registered)
// ---------------------------------------------------------------------------------------------
module scoreboard_register_file #(
    parameter int unsigned           WIDTH    = 64,
    parameter int unsigned           DEPTH    = 32,
    parameter int unsigned           NUM_READ = 3,
    parameter logic [WIDTH-1:0]      SP_INIT  = 'h0008_0000,
    localparam int unsigned          ADDR_W   = $clog2(DEPTH),
    localparam int unsigned          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NUM_READ*ADDR_W-1:0]   i_read_addr,
    output logic [NUM_READ*WIDTH-1:0]    o_read_data,
    output logic [NUM_READ-1:0]          o_read_busy,
    input  logic                         i_issue_valid,
    input  logic [ADDR_W-1:0]            i_issue_addr,
    output logic                         o_issue_ready,
    input  logic                         i_write_enable,
    input  logic [ADDR_W-1:0]            i_write_addr,
    input  logic [WIDTH-1:0]             i_write_data,
    output logic [CNT_W-1:0]             o_busy_count
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [CNT_W-1:0] r_busy_count;

    logic             w_wb_hits_issue;
    logic             w_issue_acc;
    logic             w_cnt_inc;
    logic             w_cnt_dec;
    logic [DEPTH-1:0] w_busy_d;

    // A write-back to the issue target frees it in the same cycle, so the issue may proceed.
    assign w_wb_hits_issue = i_write_enable && (i_write_addr == i_issue_addr);
    assign o_issue_ready   = !r_busy[i_issue_addr] || w_wb_hits_issue;
    assign w_issue_acc     = i_issue_valid && o_issue_ready;

    // Clear from write-back first, then set from issue, so a same-address issue wins.
    always_comb begin
        w_busy_d = r_busy;
        if (i_write_enable) begin
            w_busy_d[i_write_addr] = 1'b0;
        end
        if (w_issue_acc) begin
            w_busy_d[i_issue_addr] = 1'b1;
        end
    end

    // Count deltas: an accepted issue to an already-busy register implies a same-address
    // write-back, so the bit simply stays set and neither delta fires.
    assign w_cnt_inc = w_issue_acc && !r_busy[i_issue_addr];
    assign w_cnt_dec = i_write_enable && r_busy[i_write_addr]
                       && !(w_issue_acc && (i_issue_addr == i_write_addr));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[DEPTH-1] <= SP_INIT;
            r_busy          <= '0;
            r_busy_count    <= '0;
        end else begin
            if (i_write_enable) begin
                r_regs[i_write_addr] <= i_write_data;
            end
            r_busy <= w_busy_d;
            if (w_cnt_inc && !w_cnt_dec) begin
                r_busy_count <= r_busy_count + CNT_W'(1);
            end else if (w_cnt_dec && !w_cnt_inc) begin
                r_busy_count <= r_busy_count - CNT_W'(1);
            end
        end
    end

    assign o_busy_count = r_busy_count;

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = i_read_addr[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic w_hit;
        assign w_hit = i_write_enable && (i_write_addr == w_addr);
        assign o_read_data[g*WIDTH +: WIDTH] = w_hit ? i_write_data : r_regs[w_addr];
        assign o_read_busy[g]                = w_hit ? 1'b0 : r_busy[w_addr];
`else
        assign o_read_data[g*WIDTH +: WIDTH] = r_regs[w_addr];
        assign o_read_busy[g]                = r_busy[w_addr];
`endif
    end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// ---------------------------------------------------------------------------------------------
// tb_scoreboard_register_file
//
// Directed self-checking bench. Main instance uses default parameters (64x32, 3 read ports);
// two small instances (32x16 with 4 and 1 read ports) share a separate write port.
// Expectations for same-cycle read-during-write follow REGFILE_BYPASS_EN.
// ---------------------------------------------------------------------------------------------
module tb_scoreboard_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [63:0] SP  = 64'h0008_0000;
    localparam logic [63:0] V1  = 64'h0123_4567_89AB_CDEF;

    logic         clk = 1'b0;
    logic         reset;

    // Main instance
    logic [14:0]  ra;
    logic [191:0] rd;
    logic [2:0]   rb;
    logic         iv;
    logic [4:0]   ia;
    logic         ir;
    logic         we;
    logic [4:0]   wa;
    logic [63:0]  wd;
    logic [5:0]   bc;

    // Narrow instances
    logic [15:0]  ra4;
    logic [127:0] rd4;
    logic [3:0]   rb4;
    logic         ir4;
    logic [4:0]   bc4;
    logic [3:0]   ra1;
    logic [31:0]  rd1;
    logic [0:0]   rb1;
    logic         ir1;
    logic [4:0]   bc1;
    logic         iv4;
    logic [3:0]   ia4;
    logic         we4;
    logic [3:0]   wa4;
    logic [31:0]  wd4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scoreboard_register_file u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_read_addr    (ra),
        .o_read_data    (rd),
        .o_read_busy    (rb),
        .i_issue_valid  (iv),
        .i_issue_addr   (ia),
        .o_issue_ready  (ir),
        .i_write_enable (we),
        .i_write_addr   (wa),
        .i_write_data   (wd),
        .o_busy_count   (bc)
    );

    scoreboard_register_file #(
        .WIDTH    (32),
        .DEPTH    (16),
        .NUM_READ (4),
        .SP_INIT  (32'h0000_1000)
    ) u_dut4 (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_read_addr    (ra4),
        .o_read_data    (rd4),
        .o_read_busy    (rb4),
        .i_issue_valid  (iv4),
        .i_issue_addr   (ia4),
        .o_issue_ready  (ir4),
        .i_write_enable (we4),
        .i_write_addr   (wa4),
        .i_write_data   (wd4),
        .o_busy_count   (bc4)
    );

    scoreboard_register_file #(
        .WIDTH    (32),
        .DEPTH    (16),
        .NUM_READ (1),
        .SP_INIT  (32'h0000_1000)
    ) u_dut1 (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_read_addr    (ra1),
        .o_read_data    (rd1),
        .o_read_busy    (rb1),
        .i_issue_valid  (iv4),
        .i_issue_addr   (ia4),
        .o_issue_ready  (ir1),
        .i_write_enable (we4),
        .i_write_addr   (wa4),
        .i_write_data   (wd4),
        .o_busy_count   (bc1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic wr4(input logic [3:0] a, input logic [31:0] d);
        we4 = 1'b1;
        wa4 = a;
        wd4 = d;
        step();
    endtask

    initial begin
        reset = 1'b1;
        iv = 1'b0; ia = '0; we = 1'b0; wa = '0; wd = '0;
        iv4 = 1'b0; ia4 = '0; we4 = 1'b0; wa4 = '0; wd4 = '0;
        set_ra(5'd0, 5'd5, 5'd31);
        ra4 = {4'd15, 4'd0, 4'd0, 4'd0};
        ra1 = 4'd15;
        step();
        step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_r0", rd[63:0], 64'h0);
        check_eq("rst_r5", rd[127:64], 64'h0);
        check_eq("rst_r31", rd[191:128], SP);
        check_eq("rst_count", bc, 0);
        check_eq("rst_busy", rb, 3'b000);
        check_eq("rst_ready", ir, 1);
        check_eq("rst4_sp", rd4[127:96], 32'h0000_1000);
        check_eq("rst1_sp", rd1, 32'h0000_1000);

        // Write r1; same-cycle read depends on bypass
        step();
        we = 1'b1; wa = 5'd1; wd = V1;
        set_ra(5'd1, 5'd2, 5'd31);
        @(negedge clk);
        check_eq("wr_same_cycle", rd[63:0], BYP ? V1 : 64'h0);
        check_eq("wr_same_busy", rb[0], 0);
        step();
        we = 1'b0;
        @(negedge clk);
        check_eq("wr_r1", rd[63:0], V1);
        check_eq("wr_r2", rd[127:64], 64'h0);
        check_eq("wr_nonbusy", rb, 3'b000);

        // Issue r3, then stall a second issue to r3 until write-back
        step();
        iv = 1'b1; ia = 5'd3;
        set_ra(5'd3, 5'd0, 5'd0);
        @(negedge clk);
        check_eq("iss3_ready", ir, 1);
        check_eq("iss3_rbusy_pre", rb[0], 0);
        step();
        @(negedge clk);
        check_eq("waw_stall", ir, 0);
        check_eq("iss3_count", bc, 1);
        check_eq("iss3_rbusy", rb[0], 1);
        step();
        @(negedge clk);
        check_eq("waw_stall2", ir, 0);
        check_eq("iss3_count2", bc, 1);
        step();
        we = 1'b1; wa = 5'd3; wd = 64'h55;
        @(negedge clk);
        check_eq("wb_ready", ir, 1);
        check_eq("wb_rbusy", rb[0], BYP ? 1'b0 : 1'b1);
        check_eq("wb_rdata", rd[63:0], BYP ? 64'h55 : 64'h0);
        step();
        iv = 1'b0; we = 1'b0;
        @(negedge clk);
        check_eq("wbiss_data", rd[63:0], 64'h55);
        check_eq("wbiss_busy", rb[0], 1);
        check_eq("wbiss_count", bc, 1);

        // Retire r3
        step();
        we = 1'b1; wa = 5'd3; wd = 64'h56;
        step();
        we = 1'b0;
        @(negedge clk);
        check_eq("ret3_count", bc, 0);
        check_eq("ret3_busy", rb[0], 0);

        // Issue r4, r5, r6 back to back, then write back r5
        step();
        set_ra(5'd4, 5'd5, 5'd6);
        iv = 1'b1; ia = 5'd4;
        step();
        @(negedge clk);
        check_eq("cnt_1", bc, 1);
        ia = 5'd5;
        step();
        @(negedge clk);
        check_eq("cnt_2", bc, 2);
        ia = 5'd6;
        step();
        @(negedge clk);
        check_eq("cnt_3", bc, 3);
        iv = 1'b0;
        we = 1'b1; wa = 5'd5; wd = 64'h5;
        step();
        we = 1'b0;
        @(negedge clk);
        check_eq("cnt_wb5", bc, 2);
        check_eq("busy_456", rb, 3'b101);

        // Concurrent issue r7 and write-back r4: net zero
        step();
        iv = 1'b1; ia = 5'd7;
        we = 1'b1; wa = 5'd4; wd = 64'h4;
        step();
        iv = 1'b0; we = 1'b0;
        set_ra(5'd4, 5'd5, 5'd7);
        @(negedge clk);
        check_eq("cnt_net0", bc, 2);
        check_eq("busy_457", rb, 3'b100);

        // Make r8 busy, then reset with a write to r9 and an issue to r10 in the same cycle
        step();
        iv = 1'b1; ia = 5'd8;
        step();
        @(negedge clk);
        check_eq("cnt_pre_rst", bc, 3);
        reset = 1'b1;
        we = 1'b1; wa = 5'd9; wd = 64'hAA;
        ia = 5'd10;
        step();
        reset = 1'b0; we = 1'b0; iv = 1'b0;
        set_ra(5'd9, 5'd7, 5'd8);
        @(negedge clk);
        check_eq("mid_rst_count", bc, 0);
        check_eq("mid_rst_busy78", rb, 3'b000);
        check_eq("mid_rst_r9", rd[63:0], 64'h0);
        step();
        set_ra(5'd1, 5'd10, 5'd31);
        @(negedge clk);
        check_eq("mid_rst_r1", rd[63:0], 64'h0);
        check_eq("mid_rst_busy10", rb[1], 0);
        check_eq("mid_rst_sp", rd[191:128], SP);

        // Narrow instances: independent ports
        step();
        wr4(4'd2, 32'h1111_2222);
        wr4(4'd7, 32'h3333_4444);
        wr4(4'd9, 32'h5555_AAAA);
        wr4(4'd15, 32'hDEAD_BEEF);
        we4 = 1'b0;
        ra4 = {4'd2, 4'd9, 4'd7, 4'd15};
        ra1 = 4'd7;
        @(negedge clk);
        check_eq("n4_p0", rd4[31:0], 32'hDEAD_BEEF);
        check_eq("n4_p1", rd4[63:32], 32'h3333_4444);
        check_eq("n4_p2", rd4[95:64], 32'h5555_AAAA);
        check_eq("n4_p3", rd4[127:96], 32'h1111_2222);
        check_eq("n1_r7", rd1, 32'h3333_4444);
        check_eq("n4_count", bc4, 0);
        step();
        ra4 = {4'd15, 4'd2, 4'd0, 4'd9};
        ra1 = 4'd9;
        @(negedge clk);
        check_eq("n4_q0", rd4[31:0], 32'h5555_AAAA);
        check_eq("n4_q1", rd4[63:32], 32'h0);
        check_eq("n4_q2", rd4[95:64], 32'h1111_2222);
        check_eq("n4_q3", rd4[127:96], 32'hDEAD_BEEF);
        check_eq("n1_r9", rd1, 32'h5555_AAAA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
